// File: rtl/occ_pkg.sv
// Shared constants for the occupancy controller: parameter defaults, FSM
// state encoding, request source indices and sticky error bit positions.
package occ_pkg;

  localparam int OCC_CAPACITY_DEF = 9;
  localparam int OCC_HYST_DEF     = 2;

  typedef enum logic [0:0] {
    OPEN   = 1'b0,
    LOCKED = 1'b1
  } occ_state_e;

  // Source order matches the grant/pending vectors: {dec1, dec0, inc1, inc0}
  localparam int SRC_INC0 = 0;
  localparam int SRC_INC1 = 1;
  localparam int SRC_DEC0 = 2;
  localparam int SRC_DEC1 = 3;

  localparam int ERR_OVERFLOW  = 0;
  localparam int ERR_UNDERFLOW = 1;
  localparam int ERR_LOST      = 2;

endpackage

// File: rtl/occ_rr_arb.sv
// Two-request round-robin arbiter. The pointer names the preferred lane and
// toggles only when a grant from this arbiter is actually taken (advance).
module occ_rr_arb
  import occ_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr_reg;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr_reg ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_reg <= 1'b0;
    end else if (advance && (req != 2'b00)) begin
      ptr_reg <= ~ptr_reg;
    end
  end

endmodule

// File: rtl/occupancy_ctrl.sv
// Occupancy controller: queues lane entry/exit pulses, serves one per cycle
// (exits first), tracks count with hysteretic gate lock. OCC_STATS_EN enables total_in.
module occupancy_ctrl
  import occ_pkg::*;
#(
  parameter int CAPACITY = OCC_CAPACITY_DEF,
  parameter int HYST     = OCC_HYST_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  inc_req,
  input  logic [1:0]  dec_req,
  output logic [3:0]  count,
  output logic        full,
  output logic        empty,
  output logic        gate_lock,
  output logic [3:0]  grant,
  output logic [2:0]  err,
  output logic [15:0] total_in
);

  localparam logic [3:0] CAP4     = 4'(CAPACITY);
  localparam logic [3:0] RELEASE4 = 4'(CAPACITY - HYST);
  localparam logic [0:0] ST_OPEN   = OPEN;
  localparam logic [0:0] ST_LOCKED = LOCKED;

  logic [3:0] pend_reg, pend_next;
  logic [3:0] count_reg, count_next;
  logic [3:0] grant_reg;
  logic [2:0] err_reg, err_set;
  logic [0:0] state_reg, state_next;

  logic [3:0] req_all;
  logic [3:0] serve;
  logic [1:0] inc_gnt, dec_gnt;
  logic       dec_sel;
  logic       is_inc, is_dec, at_cap, at_zero;

  assign req_all = {dec_req, inc_req};
  assign dec_sel = pend_reg[SRC_DEC1] | pend_reg[SRC_DEC0];

  occ_rr_arb u_dec_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (pend_reg[SRC_DEC1:SRC_DEC0]),
    .advance (1'b1),
    .gnt     (dec_gnt)
  );

  // The increment arbiter only advances when no exit is pending, so a
  // blocked increment grant does not consume its lane's turn.
  occ_rr_arb u_inc_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (pend_reg[SRC_INC1:SRC_INC0]),
    .advance (~dec_sel),
    .gnt     (inc_gnt)
  );

  assign serve   = {dec_gnt, dec_sel ? 2'b00 : inc_gnt};
  assign is_inc  = serve[SRC_INC1] | serve[SRC_INC0];
  assign is_dec  = serve[SRC_DEC1] | serve[SRC_DEC0];
  assign at_cap  = (count_reg == CAP4);
  assign at_zero = (count_reg == 4'd0);

  always_comb begin
    count_next = count_reg;
    err_set    = 3'b000;
    if (is_inc) begin
      if (at_cap) err_set[ERR_OVERFLOW] = 1'b1;
      else        count_next = count_reg + 4'd1;
    end
    if (is_dec) begin
      if (at_zero) err_set[ERR_UNDERFLOW] = 1'b1;
      else         count_next = count_reg - 4'd1;
    end
    // A source being served this edge may be re-armed without loss
    err_set[ERR_LOST] = |(req_all & pend_reg & ~serve);
    pend_next = (pend_reg & ~serve) | req_all;
  end

  always_comb begin
    state_next = state_reg;
    if (state_reg == ST_OPEN) begin
      if (count_next == CAP4) state_next = ST_LOCKED;
    end else begin
      if (count_next <= RELEASE4) state_next = ST_OPEN;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_reg  <= 4'b0000;
      count_reg <= 4'd0;
      grant_reg <= 4'b0000;
      err_reg   <= 3'b000;
      state_reg <= ST_OPEN;
    end else begin
      pend_reg  <= pend_next;
      count_reg <= count_next;
      grant_reg <= serve;
      err_reg   <= err_reg | err_set;
      state_reg <= state_next;
    end
  end

  assign count     = count_reg;
  assign full      = at_cap;
  assign empty     = at_zero;
  assign gate_lock = (state_reg == ST_LOCKED);
  assign grant     = grant_reg;
  assign err       = err_reg;

`ifdef OCC_STATS_EN
  logic [15:0] total_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      total_reg <= 16'd0;
    end else if (is_inc && !at_cap && (total_reg != 16'hFFFF)) begin
      total_reg <= total_reg + 16'd1;
    end
  end

  assign total_in = total_reg;
`else
  assign total_in = 16'd0;
`endif

endmodule
